racetrack_lim_ctrl: RTL and testbench
=====================================

# racetrack_lim_ctrl

Host-side initiator for the racetrack logic-in-memory array: accepts word requests on a core-style req/gnt/rvalid port and drives the array's shift, read, write and LIM-function strobes. It tracks the shared head position, issues one shift pulse per cycle until the target domain is under the access port, then performs the access and holds off for the LIM wait period. It sits between the RI5CY LSU and the racetrack memory model, replacing a direct SRAM connection.

## Interface
- DATA_WIDTH, 32, word width.
- DOM_W, 6, log2 of domains per track (64 positions).
- ROW_W, 4, row-select width; ADDR_WIDTH = ROW_W + DOM_W.
- LIM_WAIT, WAIT_LIM_CYCLES (2), busy cycles after a LIM write; minimum 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  host request.
- we_i  in  1  1 = write/LIM, 0 = read.
- addr_i  in  ADDR_WIDTH  word address {row, domain}.
- wdata_i  in  DATA_WIDTH  write operand.
- funct_i  in  3  FUNCT_* code, writes only.
- gnt_o  out  1  request accepted.
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o  out  DATA_WIDTH  read data (0 on write responses).
- rt_shift_o  out  1  shift the array one domain.
- rt_dir_o  out  1  1 = head toward higher index, 0 = lower.
- rt_row_o  out  ROW_W  row select, valid with rd/wr.
- rt_rd_o  out  1  read strobe.
- rt_wr_o  out  1  write strobe.
- rt_funct_o  out  3  function code with rt_wr_o.
- rt_wdata_o  out  DATA_WIDTH  write operand.
- rt_rdata_i  in  DATA_WIDTH  read data, valid the cycle after rt_rd_o.

## Operation
- States: IDLE, SHIFT, ACCESS, CAPT, LIMWAIT, RESP.
- IDLE: gnt_o = req_i (combinational). On req_i & gnt_o latch we, addr, wdata, funct; next SHIFT if target domain != pos_q, else ACCESS.
- SHIFT: rt_shift_o = 1, rt_dir_o = (target > pos_q); pos_q ±1 per cycle; exit to ACCESS on the cycle pos_q reaches target. Linear track: no wrap, always shortest direct path, |target − pos_q| cycles.
- ACCESS: one cycle of rt_rd_o (read) or rt_wr_o (write) with rt_row_o. Read → CAPT. Write with funct NONE → RESP; funct XOR/AND/OR/MIN/MAX → LIMWAIT.
- CAPT: register rt_rdata_i into rdata_q → RESP.
- LIMWAIT: count LIM_WAIT cycles → RESP.
- RESP: rvalid_o = 1, rdata_o = rdata_q (reads) or 0 (writes) → IDLE. gnt_o low in every non-IDLE state.
- Funct 3'b100 and 3'b111 are reserved: forwarded as FUNCT_NONE, plain write. Reads drive rt_funct_o = 0.
- rt_* strobes are registered-state decodes, glitch-free, high only in their state.

## Timing
- Reset: state IDLE, pos_q = 0, rdata_q = 0, counter 0; all outputs 0 except gnt_o (= req_i).
- Grant cycle = 0, shift distance d. Read: rvalid at d+3. Plain write: d+2. LIM write: d+2+LIM_WAIT.
- Back-to-back: new grant possible the cycle after RESP (IDLE); no overlap.
- d = 0 skips SHIFT entirely; d = 63 (0→63) takes 63 shift cycles.
- Reset mid-operation: transaction dropped, no rvalid, pos_q = 0 (array model resets its head identically).
- req_i dropped before grant: nothing latched; request inputs ignored outside IDLE.

## Structure
- racetrack_defines gains typedef enum rt_ctrl_state_e and FUNCT_RESERVED_MASK handling constants; FUNCT_* and WAIT_LIM_CYCLES are consumed from there.
- Sub-module racetrack_head_tracker: pos_q register, direction, at_target flag, shift step; reused per-bank later.

## Test plan
- Reset, read addr {0,0} with array word 0xDEADBEEF → rvalid at cycle 3, rdata 0xDEADBEEF, no rt_shift_o pulses.
- Write 0x12345678 to domain 5 from pos 0 → five rt_shift_o pulses with dir 1, rt_wr_o at cycle 6, rvalid at 7, pos_q = 5.
- Then read domain 2 → three pulses dir 0, data matches stored value, pos_q = 2.
- LIM XOR wdata 0xFFFF0000 onto 0x0F0F0F0F → rt_funct_o = 3'b001 with rt_wr_o, rvalid 2+LIM_WAIT after access, readback 0xF0F00F0F.
- Funct 3'b111 write → rt_funct_o = 0, plain-write latency.
- Assert rst during SHIFT at pos 3 → outputs zero immediately, no rvalid, next read of domain 0 has no shift.

Source files
------------

// File: rtl/racetrack_defines.sv
`default_nettype none
// ============================================================================
//  Module   : racetrack_defines (package)
//  Purpose  : Shared constants and types for the racetrack logic-in-memory
//             host controller: LIM function codes, reserved-code handling,
//             LIM wait period and the controller state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package racetrack_defines;

  // LIM function codes carried with a write strobe
  localparam logic [2:0] FUNCT_NONE = 3'b000;
  localparam logic [2:0] FUNCT_XOR  = 3'b001;
  localparam logic [2:0] FUNCT_AND  = 3'b010;
  localparam logic [2:0] FUNCT_OR   = 3'b011;
  localparam logic [2:0] FUNCT_MIN  = 3'b101;
  localparam logic [2:0] FUNCT_MAX  = 3'b110;

  // One bit per funct code; a set bit marks the code as reserved (100, 111)
  localparam logic [7:0] FUNCT_RESERVED_MASK = 8'b1001_0000;

  // Busy cycles the array needs after a LIM write
  localparam int WAIT_LIM_CYCLES = 2;

  typedef enum logic [2:0] {
    RT_IDLE    = 3'd0,
    RT_SHIFT   = 3'd1,
    RT_ACCESS  = 3'd2,
    RT_CAPT    = 3'd3,
    RT_LIMWAIT = 3'd4,
    RT_RESP    = 3'd5
  } rt_ctrl_state_e;

  // Reserved codes degrade to a plain write
  function automatic logic [2:0] funct_sanitize(input logic [2:0] f);
    return FUNCT_RESERVED_MASK[f] ? FUNCT_NONE : f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/racetrack_head_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : racetrack_head_tracker
//  Purpose  : Tracks the shared head position of a linear racetrack and
//             steps it one domain toward a target per enabled cycle.
//  Ports    : clk, rst       - clock, async active-high reset (pos -> 0)
//             target         - domain the head must reach
//             step           - advance one domain this cycle
//             pos_q          - current head position
//             dir            - 1 = target lies at a higher index
//             last_step      - the step taken this cycle lands on target
//  Revision : 1.0 - initial release
// ============================================================================
module racetrack_head_tracker #(
  parameter int DOM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DOM_W-1:0] target,
  input  logic             step,
  output logic [DOM_W-1:0] pos_q,
  output logic             dir,
  output logic             last_step
);

  logic [DOM_W-1:0] pos_next;
  logic             at_target;

  always_comb begin
    dir       = (target > pos_q);
    at_target = (target == pos_q);
    pos_next  = dir ? pos_q + 1'b1 : pos_q - 1'b1;
    // Track is linear: when at target dir=0 and pos_q-1 never equals target
    last_step = (pos_next == target);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else if (step && !at_target) begin
      pos_q <= pos_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/racetrack_lim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : racetrack_lim_ctrl
//  Purpose  : Host-side initiator for the racetrack logic-in-memory array.
//             Accepts one word request at a time on a req/gnt/rvalid port,
//             shifts the head to the target domain, performs the read or
//             (LIM) write, waits out the LIM period and responds.
//  Ports    : clk, rst                     - clock, async active-high reset
//             req_i/we_i/addr_i/wdata_i/funct_i - host request
//             gnt_o/rvalid_o/rdata_o       - host grant and response
//             rt_shift_o/rt_dir_o          - array head shift control
//             rt_row_o/rt_rd_o/rt_wr_o     - array access strobes
//             rt_funct_o/rt_wdata_o        - write function and operand
//             rt_rdata_i                   - array read data (cycle after rd)
//  Revision : 1.0 - initial release
// ============================================================================
module racetrack_lim_ctrl
  import racetrack_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DOM_W      = 6,
  parameter int ROW_W      = 4,
  parameter int ADDR_WIDTH = ROW_W + DOM_W,
  parameter int LIM_WAIT   = WAIT_LIM_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [2:0]            funct_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rt_shift_o,
  output logic                  rt_dir_o,
  output logic [ROW_W-1:0]      rt_row_o,
  output logic                  rt_rd_o,
  output logic                  rt_wr_o,
  output logic [2:0]            rt_funct_o,
  output logic [DATA_WIDTH-1:0] rt_wdata_o,
  input  logic [DATA_WIDTH-1:0] rt_rdata_i
);

  localparam int CNT_W = $clog2(LIM_WAIT + 1);

  rt_ctrl_state_e        state_q;
  logic                  we_q;
  logic [ROW_W-1:0]      row_q;
  logic [DOM_W-1:0]      target_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      wait_cnt_q;

  logic [DOM_W-1:0]      pos_q;
  logic                  head_dir;
  logic                  last_step;
  logic [DOM_W-1:0]      req_dom;
  logic [ROW_W-1:0]      req_row;

  assign req_dom = addr_i[DOM_W-1:0];
  assign req_row = addr_i[ADDR_WIDTH-1:DOM_W];

  racetrack_head_tracker #(
    .DOM_W (DOM_W)
  ) u_head (
    .clk       (clk),
    .rst       (rst),
    .target    (target_q),
    .step      (state_q == RT_SHIFT),
    .pos_q     (pos_q),
    .dir       (head_dir),
    .last_step (last_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RT_IDLE;
      we_q       <= 1'b0;
      row_q      <= '0;
      target_q   <= '0;
      wdata_q    <= '0;
      funct_q    <= FUNCT_NONE;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        RT_IDLE: begin
          if (req_i) begin
            we_q       <= we_i;
            row_q      <= req_row;
            target_q   <= req_dom;
            wdata_q    <= wdata_i;
            // Reads always present FUNCT_NONE to the array
            funct_q    <= we_i ? funct_sanitize(funct_i) : FUNCT_NONE;
            wait_cnt_q <= '0;
            state_q    <= (req_dom != pos_q) ? RT_SHIFT : RT_ACCESS;
          end
        end
        RT_SHIFT: begin
          if (last_step) begin
            state_q <= RT_ACCESS;
          end
        end
        RT_ACCESS: begin
          if (!we_q) begin
            state_q <= RT_CAPT;
          end else if (funct_q == FUNCT_NONE) begin
            state_q <= RT_RESP;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= RT_LIMWAIT;
          end
        end
        RT_CAPT: begin
          rdata_q <= rt_rdata_i;
          state_q <= RT_RESP;
        end
        RT_LIMWAIT: begin
          if (wait_cnt_q == CNT_W'(LIM_WAIT - 1)) begin
            state_q <= RT_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        RT_RESP: begin
          state_q <= RT_IDLE;
        end
        default: begin
          state_q <= RT_IDLE;
        end
      endcase
    end
  end

  // All array-side outputs decode directly from flops so they carry no
  // combinational path from the host inputs and are zero outside their state.
  always_comb begin
    gnt_o      = (state_q == RT_IDLE) && req_i;
    rvalid_o   = (state_q == RT_RESP);
    rdata_o    = (rvalid_o && !we_q) ? rdata_q : '0;
    rt_shift_o = (state_q == RT_SHIFT);
    // Direction is constant through a shift run since the head never overshoots
    rt_dir_o   = rt_shift_o && head_dir;
    rt_rd_o    = (state_q == RT_ACCESS) && !we_q;
    rt_wr_o    = (state_q == RT_ACCESS) && we_q;
    rt_row_o   = (state_q == RT_ACCESS) ? row_q : '0;
    rt_funct_o = rt_wr_o ? funct_q : FUNCT_NONE;
    rt_wdata_o = rt_wr_o ? wdata_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_racetrack_lim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_racetrack_lim_ctrl
//  Purpose  : Self-checking bench for racetrack_lim_ctrl with a small
//             behavioural racetrack array (head position + LIM functions).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_racetrack_lim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [9:0]  addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        rt_shift_o;
  logic        rt_dir_o;
  logic [3:0]  rt_row_o;
  logic        rt_rd_o;
  logic        rt_wr_o;
  logic [2:0]  rt_funct_o;
  logic [31:0] rt_wdata_o;
  logic [31:0] rt_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  racetrack_lim_ctrl #(
    .DATA_WIDTH (32),
    .DOM_W      (6),
    .ROW_W      (4),
    .LIM_WAIT   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .funct_i    (funct_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rt_shift_o (rt_shift_o),
    .rt_dir_o   (rt_dir_o),
    .rt_row_o   (rt_row_o),
    .rt_rd_o    (rt_rd_o),
    .rt_wr_o    (rt_wr_o),
    .rt_funct_o (rt_funct_o),
    .rt_wdata_o (rt_wdata_o),
    .rt_rdata_i (rt_rdata_i)
  );

  // ---------------- behavioural racetrack array ----------------
  logic [31:0] mem [0:1023];
  logic [5:0]  mpos;
  bit          mem_init = 1'b0;

  function automatic logic [31:0] lim_op(input logic [2:0] f, input logic [31:0] o, input logic [31:0] w);
    case (f)
      3'b001:  return o ^ w;
      3'b010:  return o & w;
      3'b011:  return o | w;
      3'b101:  return (o < w) ? o : w;
      3'b110:  return (o > w) ? o : w;
      default: return w;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mpos       <= '0;
      rt_rdata_i <= '0;
    end else begin
      if (rt_shift_o) mpos <= rt_dir_o ? mpos + 6'd1 : mpos - 6'd1;
      if (rt_rd_o)    rt_rdata_i <= mem[{rt_row_o, mpos}];
    end
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'hDEADBEEF;
      mem_init <= 1'b1;
    end else if (rt_wr_o) begin
      mem[{rt_row_o, mpos}] <= lim_op(rt_funct_o, mem[{rt_row_o, mpos}], rt_wdata_o);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  row;
    logic [5:0]  dom;
    logic [31:0] wdata;
    logic [2:0]  funct;
    logic [31:0] exp_rdata;
    int          exp_shifts;
    logic        exp_dir;
    int          exp_lat;
    logic [2:0]  exp_funct;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [3:0] row, input logic [5:0] dom,
                              input logic [31:0] wdata, input logic [2:0] funct,
                              input logic [31:0] exp_rdata, input int exp_shifts,
                              input logic exp_dir, input int exp_lat, input logic [2:0] exp_funct);
    vec_t v;
    v.we = we; v.row = row; v.dom = dom; v.wdata = wdata; v.funct = funct;
    v.exp_rdata = exp_rdata; v.exp_shifts = exp_shifts; v.exp_dir = exp_dir;
    v.exp_lat = exp_lat; v.exp_funct = exp_funct;
    return v;
  endfunction

  // One transaction: grant at cycle 0, observe until rvalid (bounded).
  task automatic run_vec(input vec_t v, input string pfx);
    int          cyc = 0;
    int          shifts = 0;
    int          dir_bad = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cyc = -1;
    logic [2:0]  fseen = 3'b000;
    logic [31:0] rd = 32'h0;
    logic        got = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = v.we; addr_i = {v.row, v.dom}; wdata_i = v.wdata; funct_i = v.funct;
    #1;
    chk({pfx, "_gnt"}, {31'b0, gnt_o}, 32'd1);
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({pfx, "_gnt_busy"}, {31'b0, gnt_o}, 32'd0);
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; funct_i = '0;
      end
      if (rt_shift_o) begin
        shifts++;
        if (rt_dir_o !== v.exp_dir) dir_bad++;
      end
      if (rt_wr_o) begin wr_cnt++; wr_cyc = cyc; fseen = rt_funct_o; end
      if (rt_rd_o) rd_cnt++;
      if (rvalid_o) begin got = 1'b1; rd = rdata_o; end
    end
    chk({pfx, "_rvalid_seen"}, {31'b0, got}, 32'd1);
    chk({pfx, "_latency"}, cyc, v.exp_lat);
    chk({pfx, "_shifts"}, shifts, v.exp_shifts);
    chk({pfx, "_dir"}, dir_bad, 32'd0);
    chk({pfx, "_rdata"}, rd, v.exp_rdata);
    if (v.we) begin
      chk({pfx, "_wr_cnt"}, wr_cnt, 32'd1);
      chk({pfx, "_rd_cnt"}, rd_cnt, 32'd0);
      chk({pfx, "_wr_cycle"}, wr_cyc, v.exp_shifts + 1);
      chk({pfx, "_funct"}, {29'b0, fseen}, {29'b0, v.exp_funct});
    end else begin
      chk({pfx, "_rd_cnt"}, rd_cnt, 32'd1);
      chk({pfx, "_wr_cnt"}, wr_cnt, 32'd0);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {21'b0, gnt_o, rvalid_o, rt_shift_o, rt_dir_o, rt_rd_o, rt_wr_o, rt_funct_o, (rt_row_o != 4'd0)};
  endfunction

  vec_t vecs[19];

  initial begin
    int cyc;
    int shifts;
    int strobes;

    // Linear track, LIM_WAIT = 2: read d+3, plain write d+2, LIM write d+4
    vecs[0]  = mk(0, 4'd0,  6'd0, 32'h0,        3'b000, 32'hDEADBEEF, 0,  0, 3,  3'b000);
    vecs[1]  = mk(1, 4'd0,  6'd5, 32'h12345678, 3'b000, 32'h0,        5,  1, 7,  3'b000);
    vecs[2]  = mk(0, 4'd0,  6'd2, 32'h0,        3'b000, 32'h0,        3,  0, 6,  3'b000);
    vecs[3]  = mk(0, 4'd0,  6'd5, 32'h0,        3'b000, 32'h12345678, 3,  1, 6,  3'b000);
    vecs[4]  = mk(1, 4'd1,  6'd5, 32'h0F0F0F0F, 3'b000, 32'h0,        0,  0, 2,  3'b000);
    vecs[5]  = mk(1, 4'd1,  6'd5, 32'hFFFF0000, 3'b001, 32'h0,        0,  0, 4,  3'b001);
    vecs[6]  = mk(0, 4'd1,  6'd5, 32'h0,        3'b000, 32'hF0F00F0F, 0,  0, 3,  3'b000);
    vecs[7]  = mk(1, 4'd1,  6'd5, 32'h00FF00FF, 3'b111, 32'h0,        0,  0, 2,  3'b000);
    vecs[8]  = mk(0, 4'd1,  6'd5, 32'h0,        3'b000, 32'h00FF00FF, 0,  0, 3,  3'b000);
    vecs[9]  = mk(1, 4'd2, 6'd63, 32'hA5A5A5A5, 3'b011, 32'h0,        58, 1, 62, 3'b011);
    vecs[10] = mk(0, 4'd2, 6'd63, 32'h0,        3'b000, 32'hA5A5A5A5, 0,  0, 3,  3'b000);
    vecs[11] = mk(1, 4'd3,  6'd0, 32'h00000011, 3'b100, 32'h0,        63, 0, 65, 3'b000);
    vecs[12] = mk(0, 4'd3,  6'd0, 32'h0,        3'b000, 32'h00000011, 0,  0, 3,  3'b000);
    vecs[13] = mk(1, 4'd3,  6'd0, 32'h00000005, 3'b101, 32'h0,        0,  0, 4,  3'b101);
    vecs[14] = mk(0, 4'd3,  6'd0, 32'h0,        3'b000, 32'h00000005, 0,  0, 3,  3'b000);
    vecs[15] = mk(1, 4'd3,  6'd0, 32'h00000007, 3'b110, 32'h0,        0,  0, 4,  3'b110);
    vecs[16] = mk(0, 4'd3,  6'd0, 32'h0,        3'b000, 32'h00000007, 0,  0, 3,  3'b000);
    vecs[17] = mk(1, 4'd3,  6'd0, 32'h00000003, 3'b010, 32'h0,        0,  0, 4,  3'b010);
    vecs[18] = mk(0, 4'd3,  6'd0, 32'h0,        3'b000, 32'h00000003, 0,  0, 3,  3'b000);

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; funct_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_wdata", rt_wdata_o, 32'd0);
    req_i = 1'b1;
    #1;
    chk("reset_gnt_follows_req", {31'b0, gnt_o}, 32'd1);
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Request inputs without req_i must not start anything
    we_i = 1'b1; addr_i = {4'd0, 6'd9}; wdata_i = 32'h55; funct_i = 3'b001;
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid_o || rt_shift_o || rt_rd_o || rt_wr_o) strobes++;
    end
    chk("no_req_idle", strobes, 32'd0);
    we_i = 1'b0; addr_i = '0; wdata_i = '0; funct_i = '0;

    for (int i = 0; i < 19; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while shifting at head position 3
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = {4'd0, 6'd10};
    cyc = 0; shifts = 0;
    while (shifts < 3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin req_i = 1'b0; addr_i = '0; end
      if (rt_shift_o) shifts++;
    end
    chk("midrst_shifts_before", shifts, 32'd3);
    @(negedge clk);
    chk("midrst_still_shifting", {31'b0, rt_shift_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs_zero", outs_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (12) begin
      @(negedge clk);
      if (rvalid_o || rt_shift_o || rt_rd_o || rt_wr_o) strobes++;
    end
    chk("midrst_no_activity", strobes, 32'd0);
    run_vec(mk(0, 4'd0, 6'd0, 32'h0, 3'b000, 32'hDEADBEEF, 0, 0, 3, 3'b000), "after_rst_rd0");

    // Full-length shift 0 -> 63
    run_vec(mk(0, 4'd0, 6'd63, 32'h0, 3'b000, 32'h0, 63, 1, 66, 3'b000), "rd_dom63");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
